// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor resolve path: 2-bit counter states,
// BTB entry layout, in-flight prediction record and the counter update rule.
package bp_pkg;

  localparam int BP_XLEN  = 32;
  localparam int BP_IDX_W = 5;
  localparam int BP_DEPTH = 4;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bp_state_t;

  typedef struct packed {
    logic [BP_XLEN-1:0] target;
    bp_state_t          state;
    logic               pred;
  } btb_entry_t;

  typedef struct packed {
    logic [BP_XLEN-1:0]  pc;
    logic [BP_IDX_W-1:0] index;
    logic [BP_XLEN-1:0]  target;
    bp_state_t           state;
    logic                pred;
  } bp_rec_t;

  // A weakly-not-taken counter jumps straight to strong-taken on a taken
  // outcome; this asymmetry is intentional.
  function automatic bp_state_t bp_next_state(bp_state_t state, logic taken);
    bp_state_t nxt;
    nxt = STRONG_NT;
    case (state)
      STRONG_NT: nxt = taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   nxt = taken ? STRONG_T : STRONG_NT;
      WEAK_T:    nxt = taken ? STRONG_T : STRONG_NT;
      default:   nxt = taken ? STRONG_T : WEAK_T;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-order queue of in-flight prediction records. Push/pop arrive already
// qualified by the parent; flush clears pointers and count and wins over both.
module bp_inflight_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 72
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Record storage; contents are don't-care while not counted, so no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/bp_resolve_unit.sv
// Execute-side end of the branch predictor. Holds fetch-time predictions in
// an in-order queue, compares the oldest against the execute outcome, and
// emits a registered redirect plus a BTB write-back for every resolution.
// Optional build macro BP_STATS_EN adds saturating stat_branches/stat_mispred.
module bp_resolve_unit
  import bp_pkg::*;
#(
  parameter int DEPTH = BP_DEPTH,
  parameter int IDX_W = BP_IDX_W,
  parameter int XLEN  = BP_XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             f_valid,
  output logic             f_ready,
  input  logic [XLEN-1:0]  f_pc,
  input  logic [IDX_W-1:0] f_index,
  input  logic [XLEN-1:0]  f_target,
  input  logic [1:0]       f_state,
  input  logic             f_pred,
  input  logic             e_valid,
  input  logic             e_taken,
  input  logic [XLEN-1:0]  e_target,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             btb_we,
  output logic [IDX_W-1:0] btb_windex,
  output logic [XLEN+2:0]  btb_wdata
`ifdef BP_STATS_EN
  ,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispred
`endif
);

  localparam int REC_W = XLEN + IDX_W + XLEN + 3;

  logic [REC_W-1:0] push_rec;
  logic [REC_W-1:0] head;
  logic             full;
  logic             empty;
  logic             pop_ok;
  logic             push_ok;
  logic             flush;
  logic             mis;

  logic [XLEN-1:0]  head_pc;
  logic [IDX_W-1:0] head_index;
  logic [XLEN-1:0]  head_target;
  bp_state_t        head_state;
  logic             head_pred;
  bp_state_t        new_state;
  logic [XLEN-1:0]  new_target;

  assign push_rec    = {f_pc, f_index, f_target, f_state, f_pred};
  assign head_pred   = head[0];
  assign head_state  = bp_state_t'(head[2:1]);
  assign head_target = head[XLEN+2:3];
  assign head_index  = head[XLEN+IDX_W+2:XLEN+3];
  assign head_pc     = head[REC_W-1:XLEN+IDX_W+3];

  assign pop_ok = e_valid & ~empty;
  assign mis    = (e_taken != head_pred) |
                  (e_taken & head_pred & (e_target != head_target));
  assign flush  = pop_ok & mis;

  // A full queue still accepts a push in a cycle that pops, so the occupancy
  // holds at DEPTH; a push alongside a flushing pop is discarded.
  assign push_ok = f_valid & (~full | pop_ok) & ~flush;
  assign f_ready = ~full;

  assign new_state  = bp_next_state(head_state, e_taken);
  assign new_target = e_taken ? e_target : head_target;

  bp_inflight_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_ok),
    .pop   (pop_ok),
    .flush (flush),
    .wdata (push_rec),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Resolution results registered one cycle after the pop; data holds between pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
      btb_we      <= 1'b0;
      btb_windex  <= '0;
      btb_wdata   <= '0;
    end else begin
      btb_we     <= pop_ok;
      mispredict <= flush;
      if (pop_ok) begin
        redirect_pc <= e_taken ? e_target : head_pc + XLEN'(4);
        btb_windex  <= head_index;
        btb_wdata   <= {new_target, new_state, new_state[1]};
      end
    end
  end

`ifdef BP_STATS_EN
  // Saturating counts of resolved branches and of mispredicts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (pop_ok && (stat_branches != 32'hFFFF_FFFF)) stat_branches <= stat_branches + 32'd1;
      if (flush && (stat_mispred != 32'hFFFF_FFFF))   stat_mispred  <= stat_mispred + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_resolve_unit.sv
// Self-checking bench for bp_resolve_unit: directed scenarios followed by a
// random phase, all compared against a queue-based reference model.
module tb_bp_resolve_unit;
  import bp_pkg::*;

  localparam int XLEN  = 32;
  localparam int IDX_W = 5;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             f_valid = 1'b0;
  logic             f_ready;
  logic [XLEN-1:0]  f_pc = '0;
  logic [IDX_W-1:0] f_index = '0;
  logic [XLEN-1:0]  f_target = '0;
  logic [1:0]       f_state = '0;
  logic             f_pred = 1'b0;
  logic             e_valid = 1'b0;
  logic             e_taken = 1'b0;
  logic [XLEN-1:0]  e_target = '0;
  logic             mispredict;
  logic [XLEN-1:0]  redirect_pc;
  logic             btb_we;
  logic [IDX_W-1:0] btb_windex;
  logic [XLEN+2:0]  btb_wdata;
`ifdef BP_STATS_EN
  logic [31:0]      stat_branches;
  logic [31:0]      stat_mispred;
`endif

  bp_resolve_unit #(.DEPTH(DEPTH), .IDX_W(IDX_W), .XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .f_valid     (f_valid),
    .f_ready     (f_ready),
    .f_pc        (f_pc),
    .f_index     (f_index),
    .f_target    (f_target),
    .f_state     (f_state),
    .f_pred      (f_pred),
    .e_valid     (e_valid),
    .e_taken     (e_taken),
    .e_target    (e_target),
    .mispredict  (mispredict),
    .redirect_pc (redirect_pc),
    .btb_we      (btb_we),
    .btb_windex  (btb_windex),
    .btb_wdata   (btb_wdata)
`ifdef BP_STATS_EN
    ,
    .stat_branches (stat_branches),
    .stat_mispred  (stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bp_rec_t     q[$];
  logic        exp_we;
  logic        exp_mis;
  logic [31:0] exp_redir;
  logic [4:0]  exp_idx;
  logic [34:0] exp_wdata;
  int unsigned exp_br = 0;
  int unsigned exp_mp = 0;

  // Counter update straight from the state table: taken saturates towards 11
  // (00 only reaches 01), not-taken drops 11 to 10 and everything else to 00.
  function automatic logic [1:0] ref_next(input logic [1:0] s, input logic t);
    if (t) return (s == 2'b00) ? 2'b01 : 2'b11;
    else   return (s == 2'b11) ? 2'b10 : 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive, check f_ready, advance the model, clock, check outputs.
  task automatic step(input logic fv, input logic [31:0] pc, input logic [4:0] idx,
                      input logic [31:0] tgt, input logic [1:0] st, input logic pr,
                      input logic ev, input logic tk, input logic [31:0] et);
    bp_rec_t    h;
    logic       pop;
    logic       mis;
    logic       acc;
    logic [1:0] ns;
    f_valid = fv; f_pc = pc; f_index = idx; f_target = tgt; f_state = st; f_pred = pr;
    e_valid = ev; e_taken = tk; e_target = et;
    #1;
    chk("f_ready", {63'd0, f_ready}, {63'd0, q.size() < DEPTH});
    pop = ev && (q.size() > 0);
    mis = 1'b0;
    exp_we  = pop;
    exp_mis = 1'b0;
    if (pop) begin
      h = q[0];
      mis = (tk != h.pred) || (tk && h.pred && (et != h.target));
      ns  = ref_next(h.state, tk);
      exp_mis   = mis;
      exp_redir = tk ? et : h.pc + 32'd4;
      exp_idx   = h.index;
      exp_wdata = {(tk ? et : h.target), ns, ns[1]};
      exp_br++;
      if (mis) exp_mp++;
    end
    acc = fv && ((q.size() < DEPTH) || pop) && !(pop && mis);
    if (pop && mis) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{pc, idx, tgt, bp_state_t'(st), pr});
    end
    @(posedge clk);
    #1;
    f_valid = 1'b0;
    e_valid = 1'b0;
    chk("btb_we", {63'd0, btb_we}, {63'd0, exp_we});
    chk("mispredict", {63'd0, mispredict}, {63'd0, exp_mis});
    if (exp_we) begin
      chk("redirect_pc", {32'd0, redirect_pc}, {32'd0, exp_redir});
      chk("btb_windex", {59'd0, btb_windex}, {59'd0, exp_idx});
      chk("btb_wdata", {29'd0, btb_wdata}, {29'd0, exp_wdata});
    end
`ifdef BP_STATS_EN
    chk("stat_branches", {32'd0, stat_branches}, {32'd0, exp_br});
    chk("stat_mispred", {32'd0, stat_mispred}, {32'd0, exp_mp});
`endif
  endtask

  initial begin
    int          exp_ids[4];
    logic [31:0] et;
    logic [31:0] tg;
    exp_ids = '{9, 10, 11, 21};

    // Reset state
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_f_ready", {63'd0, f_ready}, 64'd1);
    chk("rst_mispredict", {63'd0, mispredict}, 64'd0);
    chk("rst_btb_we", {63'd0, btb_we}, 64'd0);
    chk("rst_redirect", {32'd0, redirect_pc}, 64'd0);
    chk("rst_wdata", {29'd0, btb_wdata}, 64'd0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 32'h50);
    chk("empty_pop_we", {63'd0, btb_we}, 64'd0);

    // Not-taken prediction resolves taken
    step(1, 32'h100, 3, 32'h0, 2'b00, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 32'h200);
    chk("t2_mis", {63'd0, mispredict}, 64'd1);
    chk("t2_redirect", {32'd0, redirect_pc}, 64'h200);
    chk("t2_windex", {59'd0, btb_windex}, 64'd3);
    chk("t2_wdata", {29'd0, btb_wdata}, {29'd0, 32'h200, 2'b01, 1'b0});

    // Correct strong-taken, then strong-taken resolved not-taken
    step(1, 32'h380, 4, 32'h400, 2'b11, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 32'h400);
    chk("t3a_mis", {63'd0, mispredict}, 64'd0);
    chk("t3a_wdata", {29'd0, btb_wdata}, {29'd0, 32'h400, 2'b11, 1'b1});
    step(1, 32'h300, 5, 32'h400, 2'b11, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 32'h0);
    chk("t3b_redirect", {32'd0, redirect_pc}, 64'h304);
    chk("t3b_wdata", {29'd0, btb_wdata}, {29'd0, 32'h400, 2'b10, 1'b1});

    // Fill, drop on full, push+pop while full, in-order drain
    for (int i = 0; i < 4; i++)
      step(1, 32'h1000 + 32'(16 * i), 5'(8 + i), 32'h2000 + 32'(i), 2'b11, 1, 0, 0, 0);
    chk("full_ready", {63'd0, f_ready}, 64'd0);
    step(1, 32'h1040, 20, 32'h2040, 2'b11, 1, 0, 0, 0);
    step(1, 32'h1100, 21, 32'h2100, 2'b11, 1, 1, 1, 32'h2000);
    chk("pushpop_full_ready", {63'd0, f_ready}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      et = (q.size() > 0) ? q[0].target : 32'h0;
      step(0, 0, 0, 0, 0, 0, 1, 1, et);
      chk("drain_order", {59'd0, btb_windex}, 64'(exp_ids[i]));
    end

    // Oldest of three mispredicts with a simultaneous push
    for (int i = 0; i < 3; i++)
      step(1, 32'h3000 + 32'(4 * i), 5'(i), 32'h3800, 2'b00, 0, 0, 0, 0);
    step(1, 32'h3100, 7, 32'h3900, 2'b00, 0, 1, 1, 32'h3500);
    chk("flush_mis", {63'd0, mispredict}, 64'd1);
    chk("flush_ready", {63'd0, f_ready}, 64'd1);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("flush_empty_we", {63'd0, btb_we}, 64'd0);

    // Asynchronous reset mid-stream
    step(1, 32'h500, 12, 32'h600, 2'b11, 1, 0, 0, 0);
    step(1, 32'h504, 13, 32'h604, 2'b11, 1, 0, 0, 0);
    step(1, 32'h508, 14, 32'h608, 2'b11, 1, 1, 1, 32'h600);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we", {63'd0, btb_we}, 64'd0);
    chk("arst_windex", {59'd0, btb_windex}, 64'd0);
    chk("arst_wdata", {29'd0, btb_wdata}, 64'd0);
    chk("arst_redirect", {32'd0, redirect_pc}, 64'd0);
    chk("arst_ready", {63'd0, f_ready}, 64'd1);
    q.delete();
    exp_br = 0;
    exp_mp = 0;
`ifdef BP_STATS_EN
    chk("arst_stat_br", {32'd0, stat_branches}, 64'd0);
    chk("arst_stat_mp", {32'd0, stat_mispred}, 64'd0);
`endif
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    step(0, 0, 0, 0, 0, 0, 1, 1, 32'h600);
    chk("arst_empty_we", {63'd0, btb_we}, 64'd0);
    step(1, 32'h700, 2, 32'h780, 2'b10, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 32'h790);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      tg = ($urandom_range(0, 1) != 0) ? 32'h40 : 32'h80;
      if ((q.size() > 0) && ($urandom_range(0, 1) != 0)) et = q[0].target;
      else et = ($urandom_range(0, 1) != 0) ? 32'h40 : 32'hC0;
      step(($urandom_range(0, 2) != 0), {$urandom_range(0, 32'h3FFF), 2'b00}, 5'($urandom_range(0, 31)),
           tg, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 1) != 0), 1'($urandom_range(0, 1)), et);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
